// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: byte FIFO plus launch sequencer feeding a UART transmitter.
// Bytes are queued from the system side and launched one at a time on uart_din/uart_en,
// paced by uart_tx_busy. A launch that never sees busy is retried after a short low gap.
// Optional feature: define UART_TX_FIFO_DROP_CNT_EN to add a saturating drop counter port.
module uart_tx_fifo_ctrl #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  input  logic              uart_tx_busy,
  output logic              uart_en,
  output logic [7:0]        uart_din,
`ifdef UART_TX_FIFO_DROP_CNT_EN
  output logic              overflow,
  output logic [7:0]        drop_cnt
`else
  output logic              overflow
`endif
);

  localparam int unsigned     TmoW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);
  localparam logic [TmoW-1:0] TmoLast   = TmoW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPulse,
    StWaitDone,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q;
  logic              uart_en_q, uart_en_d;
  logic [7:0]        din_q;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              gap_q, gap_d;
  logic              ovf_q;
  logic              push, pop, drop;

  // Full is the registered flag, so a write while full is dropped even if LOAD pops.
  assign push = wr_en & ~full_q;
  assign drop = wr_en & full_q;
  assign pop  = (state_q == StLoad);

  // Occupancy next state; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Launch sequencer next state and uart_en/timer next values.
  always_comb begin
    state_d   = state_q;
    uart_en_d = uart_en_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    unique case (state_q)
      StIdle: begin
        if (!empty_q && !uart_tx_busy) state_d = StLoad;
      end
      StLoad: begin
        uart_en_d = 1'b1;
        tmo_d     = '0;
        state_d   = StPulse;
      end
      StPulse: begin
        if (uart_tx_busy) begin
          uart_en_d = 1'b0;
          state_d   = StWaitDone;
        end else if (tmo_q == TmoLast) begin
          // No acknowledge: drop the request and relaunch the same byte after the gap.
          uart_en_d = 1'b0;
          gap_d     = 1'b0;
          state_d   = StGap;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StGap: begin
        // Two low cycles so the transmitter's synchroniser sees a clean rising edge.
        if (gap_q) begin
          uart_en_d = 1'b1;
          tmo_d     = '0;
          state_d   = StPulse;
        end else begin
          gap_d = 1'b1;
        end
      end
      StWaitDone: begin
        uart_en_d = 1'b0;
        if (!uart_tx_busy) state_d = StIdle;
      end
      default: begin
        uart_en_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointers, flags, launch register and timers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      uart_en_q <= 1'b0;
      din_q     <= 8'h00;
      tmo_q     <= '0;
      gap_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        din_q    <= mem_q[rd_ptr_q];
      end
      count_q   <= count_d;
      full_q    <= (count_d == FullCount);
      empty_q   <= (count_d == '0);
      uart_en_q <= uart_en_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef UART_TX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  // Saturating count of writes dropped while full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= 8'h00;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign uart_en  = uart_en_q;
  assign uart_din = din_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Bench for uart_tx_fifo_ctrl: transmitter model with a short bit period, a queue-based
// reference of the FIFO, a per-cycle compare process and directed scenarios.
module tb_uart_tx_fifo_ctrl;

  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;
  localparam int ACK_TIMEOUT = 8;
  localparam int CPB         = 8;  // shortened bit period keeps the run small

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              wr_en   = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              full, empty, uart_tx_busy, uart_en, overflow;
  logic [ADDR_W:0]   count;
  logic [7:0]        uart_din;
`ifdef UART_TX_FIFO_DROP_CNT_EN
  logic [7:0]        drop_cnt;
  int                m_drops = 0;
`endif

  always #5 clk = ~clk;

  uart_tx_fifo_ctrl #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .uart_tx_busy (uart_tx_busy),
    .uart_en      (uart_en),
    .uart_din     (uart_din),
    .overflow     (overflow)
`ifdef UART_TX_FIFO_DROP_CNT_EN
    ,.drop_cnt    (drop_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic report(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transmitter model ----------------
  logic       s1 = 1'b0, s2 = 1'b0, fb = 1'b0, tx_mute = 1'b0, tx_hold = 1'b0;
  logic [9:0] shreg   = '1;
  logic [7:0] tx_byte = 8'h00;
  int         clkcnt  = 0, bitcnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] sent_log[$];
  int         line_log[$];

  assign uart_tx_busy = fb | tx_hold;

  always @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      fb <= 1'b0;
    end else begin
      s1 <= uart_en;
      s2 <= s1;
      if (fb) begin
        if (clkcnt == CPB / 2) line_log.push_back(int'(shreg[0]));
        if (clkcnt == CPB - 1) begin
          clkcnt <= 0;
          shreg  <= {1'b1, shreg[9:1]};
          if (bitcnt == 9) fb <= 1'b0;
          else bitcnt <= bitcnt + 1;
        end else begin
          clkcnt <= clkcnt + 1;
        end
      end else if (s1 && !s2 && !tx_mute) begin
        fb      <= 1'b1;
        tx_byte <= uart_din;
        shreg   <= {1'b1, uart_din, 1'b0};
        clkcnt  <= 0;
        bitcnt  <= 0;
        got_q.push_back(uart_din);
        sent_log.push_back(uart_din);
      end
    end
  end

  // ---------------- reference model ----------------
  typedef enum {MIdle, MLoad, MFlight} mph_e;
  mph_e       m_ph   = MIdle;
  logic       m_seen = 1'b0;
  logic       m_ovf  = 1'b0;
  logic [7:0] m_q[$];
  logic [7:0] exp_tx[$];
  int         m_sz;

  always @(posedge clk) begin
    m_sz = m_q.size();
    if (!rst_n) begin
      m_q.delete();
      exp_tx.delete();
      m_ph   = MIdle;
      m_seen = 1'b0;
      m_ovf  = 1'b0;
`ifdef UART_TX_FIFO_DROP_CNT_EN
      m_drops = 0;
`endif
    end else begin
      if (m_ph == MLoad) begin
        exp_tx.push_back(m_q[0]);
        void'(m_q.pop_front());
      end
      if (wr_en) begin
        if (m_sz == DEPTH) begin
          m_ovf = 1'b1;
`ifdef UART_TX_FIFO_DROP_CNT_EN
          if (m_drops < 255) m_drops++;
`endif
        end else begin
          m_q.push_back(wr_data);
        end
      end
      case (m_ph)
        MIdle: if (m_sz != 0 && !uart_tx_busy) m_ph = MLoad;
        MLoad: begin
          m_ph   = MFlight;
          m_seen = 1'b0;
        end
        default: begin
          if (uart_tx_busy) m_seen = 1'b1;
          else if (m_seen) m_ph = MIdle;
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  logic       chk_en  = 1'b0;
  logic       prev_en = 1'b0;
  logic [7:0] g;

  always @(negedge clk) begin
    if (chk_en) begin
      report("count", int'(count), m_q.size());
      report("empty", int'(empty), int'(m_q.size() == 0));
      report("full", int'(full), int'(m_q.size() == DEPTH));
      report("overflow", int'(overflow), int'(m_ovf));
`ifdef UART_TX_FIFO_DROP_CNT_EN
      report("drop_cnt", int'(drop_cnt), m_drops);
`endif
      if (fb) report("din_stable", int'(uart_din), int'(tx_byte));
      if (uart_en && !prev_en) report("en_rise_busy_low", int'(uart_tx_busy), 0);
      while (got_q.size() != 0) begin
        g = got_q.pop_front();
        if (exp_tx.size() == 0) report("tx_extra", int'(g), -1);
        else report("tx_order", int'(g), int'(exp_tx.pop_front()));
      end
    end
    prev_en = uart_en;
  end

  // ---------------- helpers ----------------
  task automatic wait_idle(input string name, input int lim);
    int n = 0;
    int quiet = 0;
    while (quiet < 4 && n < lim) begin
      @(negedge clk);
      n++;
      if (empty && !uart_tx_busy && !uart_en) quiet++;
      else quiet = 0;
    end
    report(name, int'(quiet >= 4), 1);
  endtask

  int exp_line[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int hi;
    int lo;
    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    report("rst_empty", int'(empty), 1);
    report("rst_full", int'(full), 0);
    report("rst_count", int'(count), 0);
    report("rst_en", int'(uart_en), 0);
    report("rst_din", int'(uart_din), 0);
    report("rst_ovf", int'(overflow), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Single byte
    line_log.delete();
    sent_log.delete();
    wr_en = 1'b1;
    wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    report("t1_count_n", int'(count), 1);
    report("t1_en_n", int'(uart_en), 0);
    @(negedge clk);
    report("t1_en_n1", int'(uart_en), 0);
    @(negedge clk);
    report("t1_en_n2", int'(uart_en), 1);
    report("t1_din", int'(uart_din), 'hA5);
    n = 0;
    while (!uart_tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    report("t1_busy_seen", int'(uart_tx_busy), 1);
    report("t1_din_busy", int'(uart_din), 'hA5);
    wait_idle("t1_idle", 400);
    report("t1_empty", int'(empty), 1);
    report("t1_line_len", line_log.size(), 10);
    for (int i = 0; i < 10 && i < line_log.size(); i++) report("t1_line_bit", line_log[i],
                                                               exp_line[i]);

    // 2. Burst of 16 with the transmitter held busy
    sent_log.delete();
    tx_hold = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(i + 1);
      @(negedge clk);
    end
    wr_en = 1'b0;
    report("t2_full", int'(full), 1);
    report("t2_count", int'(count), 16);
    tx_hold = 1'b0;
    wait_idle("t2_idle", 3000);
    report("t2_frames", sent_log.size(), 16);
    for (int i = 0; i < 16 && i < sent_log.size(); i++) report("t2_order", int'(sent_log[i]),
                                                               i + 1);
    report("t2_count0", int'(count), 0);

    // 3. Overflow
    sent_log.delete();
    wr_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'(8'h20 + i);
      @(negedge clk);
    end
    report("t3_full", int'(full), 1);
    report("t3_count", int'(count), 16);
    report("t3_no_ovf", int'(overflow), 0);
    wr_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    report("t3_ovf", int'(overflow), 1);
    report("t3_count_kept", int'(count), 16);
`ifdef UART_TX_FIFO_DROP_CNT_EN
    report("t3_drop_cnt", int'(drop_cnt), 1);
`endif
    wait_idle("t3_idle", 3000);
    report("t3_frames", sent_log.size(), 17);
    for (int i = 0; i < 17 && i < sent_log.size(); i++) report("t3_order", int'(sent_log[i]),
                                                               'h20 + i);
    report("t3_ovf_sticky", int'(overflow), 1);

    // 4. Timeout and retry
    sent_log.delete();
    tx_mute = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    while (!uart_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    report("t4_en_rise", int'(uart_en), 1);
    hi = 0;
    while (uart_en && hi < 50) begin
      @(negedge clk);
      hi++;
    end
    report("t4_high_cycles", hi, ACK_TIMEOUT);
    lo = 0;
    while (!uart_en && lo < 50) begin
      @(negedge clk);
      lo++;
    end
    report("t4_gap_cycles", lo, 2);
    report("t4_din_same", int'(uart_din), 'h3C);
    report("t4_count", int'(count), 0);
    repeat (9) @(negedge clk);
    tx_mute = 1'b0;
    wait_idle("t4_idle", 400);
    report("t4_frames", sent_log.size(), 1);
    if (sent_log.size() != 0) report("t4_byte", int'(sent_log[0]), 'h3C);

    // 5. Reset during the third of five frames
    sent_log.delete();
    tx_hold = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'h50 + i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    tx_hold = 1'b0;
    n = 0;
    while (sent_log.size() < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    report("t5_third_frame", sent_log.size(), 3);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    report("t5_en", int'(uart_en), 0);
    report("t5_empty", int'(empty), 1);
    report("t5_count", int'(count), 0);
    report("t5_ovf", int'(overflow), 0);
    repeat (300) @(negedge clk);
    report("t5_no_more_frames", sent_log.size(), 3);
    report("t5_en_quiet", int'(uart_en), 0);

    // 6. Write landing in the LOAD cycle
    sent_log.delete();
    tx_hold = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(8'h61 + i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    report("t6_count3", int'(count), 3);
    tx_hold = 1'b0;
    @(negedge clk);
    report("t6_pre_load", int'(count), 3);
    wr_en = 1'b1;
    wr_data = 8'h64;
    @(negedge clk);
    wr_en = 1'b0;
    report("t6_count_kept", int'(count), 3);
    report("t6_en", int'(uart_en), 1);
    wait_idle("t6_idle", 1000);
    report("t6_frames", sent_log.size(), 4);
    for (int i = 0; i < 4 && i < sent_log.size(); i++) report("t6_order", int'(sent_log[i]),
                                                              'h61 + i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
